ram8_loader: RTL and testbench
==============================

RAM8_LOADER -- requirements
Module: ram8_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM port address width (2048 bytes).
REQ-002 SHALL have parameter DATA_W, default 8, RAM port data width.
REQ-003 SHALL have one clock, clk; reset rst is asynchronous and active-high.
REQ-004 SHALL have ports, in this order:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  job request; accepted only in IDLE.
- base_addr  input  ADDR_W  first RAM address, sampled at start.
- len_m1  input  ADDR_W  byte count minus 1, sampled at start (1..2048 bytes).
- in_valid  input  1  stream byte valid.
- in_data  input  DATA_W  stream byte.
- in_ready  output  1  stream byte accepted when in_valid is also high.
- ram_addr  output  ADDR_W  address to one RAM8 port.
- ram_din  output  DATA_W  write data to the RAM port.
- ram_we  output  1  write enable to the RAM port.
- ram_q  input  DATA_W  RAM port read data, valid one clk after ram_addr.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  readback checksum mismatch.
- chk  output  DATA_W  XOR of all readback bytes.

Function
REQ-005 SHALL implement the states IDLE, WRITE, READ, DRAIN.
REQ-006 IDLE: start=1 SHALL latch base_addr and len_m1, clear cnt, the write checksum, the read checksum and error, and move to WRITE; start SHALL be ignored in all other states.
REQ-007 in_ready SHALL equal 1 only in WRITE.
REQ-008 In WRITE, ram_we SHALL equal in_valid; ram_din SHALL equal in_data; ram_addr SHALL equal (base+cnt) mod 2^ADDR_W. These outputs are combinational.
REQ-009 Each WRITE handshake cycle SHALL XOR in_data into the write checksum and increment cnt.
REQ-010 A cycle with in_valid=0 SHALL produce no write and SHALL NOT advance cnt.
REQ-011 The handshake with cnt==len_m1 SHALL clear cnt and move to READ.
REQ-012 In READ, ram_we SHALL be 0 and ram_addr SHALL be (base+cnt) mod 2^ADDR_W.
REQ-013 cnt SHALL increment every READ cycle.
REQ-014 At cnt==len_m1, the state SHALL move to DRAIN on the next edge.
REQ-015 From the second READ cycle through DRAIN, each cycle SHALL XOR ram_q into the read checksum (one-cycle RAM latency); exactly len_m1+1 bytes SHALL be accumulated.
REQ-016 DRAIN SHALL last one cycle and then return to IDLE.
REQ-017 On the DRAIN-to-IDLE edge, the block SHALL register done=1 for one cycle and error=(read checksum != write checksum).
REQ-018 chk SHALL be valid from the done cycle.
REQ-019 error and chk SHALL hold until the next accepted start.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_W (0x7FF+1 -> 0x000).
REQ-021 Outside WRITE, ram_we SHALL be 0; ram_addr and ram_din SHALL be 0 in IDLE.
REQ-022 A start in the same cycle as done SHALL be accepted.
REQ-023 With no stalls, total job latency SHALL be 2N+2 cycles from start acceptance to done, where N=len_m1+1.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, with every register and output cleared: cnt, checksums, busy, done, error, chk, in_ready, ram_we, ram_addr and ram_din all 0.
REQ-025 Reset mid-job SHALL abort the job with no done pulse and no further writes; RAM contents already written are unaffected.
REQ-026 After rst deasserts, the first start SHALL begin a clean job.

Verification
REQ-027 Basic job: base=0x000, len_m1=3, bytes 48,0F,4C,FE streamed back-to-back -> ram_we high on 4 cycles at addresses 000..003, then 4 read addresses 000..003; done after 10 cycles total, chk=0xF5, error=0.
REQ-028 Wrap-around: base=0x7FE, len_m1=3 -> write and read addresses are 7FE, 7FF, 000, 001; error=0.
REQ-029 Backpressure gaps: in_valid pattern 1,0,0,1,1,0,1 for len_m1=3 -> ram_we=0 on every gap cycle, exactly 4 writes, and the checksum matches the 4-byte stream.
REQ-030 Corruption: the bench RAM model returns data^0x01 for address 0x002 during READ -> error=1 with done; chk differs from the write checksum by 0x01.
REQ-031 Reset mid-WRITE: rst pulsed after 2 of 4 handshakes -> busy=0, in_ready=0, ram_we=0 immediately; no done pulse; a new start then completes normally with error=0.
REQ-032 Start while busy: start pulses during WRITE and during READ with a different base_addr -> ignored; the job completes using the original base_addr and len_m1.

Source files
------------

// File: rtl/ram8_loader.sv
// ram8_loader: streams len_m1+1 bytes into one RAM8 port, reads them back and compares XOR checksums.
// Latency: 2N+2 cycles from accepted start to done with no input stalls (N = len_m1+1).
// Backpressure: in_ready is high only in WRITE; in_valid gaps stall the write phase with no write.
// Ports: clk/rst (async active-high); start, base_addr, len_m1 job request sampled in IDLE;
//   in_valid/in_data/in_ready byte stream; ram_addr/ram_din/ram_we/ram_q to a single RAM port
//   (ram_q one cycle behind ram_addr); busy, done pulse, error and chk readback status.
module ram8_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] chk
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] wchk;
  logic [DATA_W-1:0] rchk;
  logic              done_q;
  logic              error_q;
  logic              last;

  assign last  = (cnt == len);
  assign busy  = (state != IDLE);
  assign done  = done_q;
  assign error = error_q;
  assign chk   = rchk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the combinational RAM/stream outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WRITE;
      end
      WRITE: begin
        in_ready = 1'b1;
        ram_we   = in_valid;
        ram_din  = in_data;
        ram_addr = base + cnt;  // truncation gives the modulo-2^ADDR_W wrap
        if (in_valid && last) state_nxt = READ;
      end
      READ: begin
        ram_addr = base + cnt;
        if (last) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base    <= '0;
      len     <= '0;
      cnt     <= '0;
      wchk    <= '0;
      rchk    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base    <= base_addr;
            len     <= len_m1;
            cnt     <= '0;
            wchk    <= '0;
            rchk    <= '0;
            error_q <= 1'b0;
          end
        end
        WRITE: begin
          if (in_valid) begin
            wchk <= wchk ^ in_data;
            cnt  <= last ? '0 : cnt + ONE;
          end
        end
        READ: begin
          cnt <= cnt + ONE;
          // ram_q lags the address by one cycle, so the first READ cycle has nothing to fold in.
          if (cnt != '0) rchk <= rchk ^ ram_q;
        end
        DRAIN: begin
          // Last readback byte arrives here; compare against the fully folded value.
          rchk    <= rchk ^ ram_q;
          done_q  <= 1'b1;
          error_q <= ((rchk ^ ram_q) != wchk);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_loader.sv
// tb_ram8_loader: directed plus randomized jobs against ram8_loader with a RAM model and checksum reference.
// Latency: checks done arrives 2N+2 cycles after the start cycle for stall-free jobs.
// Backpressure: drives fixed and random in_valid gap patterns and checks no write happens on gaps.
module tb_ram8_loader;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] len_m1;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_q;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] chk;

  ram8_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len_m1(len_m1),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q),
    .busy(busy), .done(done), .error(error), .chk(chk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // RAM model: synchronous write, one-cycle registered read, optional corruption of address 2 on reads.
  logic [DW-1:0] mem [DEPTH];
  logic          corrupt = 1'b0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr] ^ ((corrupt && busy && !in_ready && ram_addr == AW'(2)) ? 8'h01 : 8'h00);
    cyc <= cyc + 1;
  end

  // Mid-cycle monitor of every cycle's port activity.
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_dat_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [DW-1:0] data_q[$];
  int we_bad = 0;
  int idle_bad = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_addr_q.push_back(ram_addr);
      wr_dat_q.push_back(ram_din);
    end
    if (busy === 1'b1 && in_ready === 1'b0) rd_addr_q.push_back(ram_addr);
    if (ram_we !== (in_ready & in_valid)) we_bad++;
    if (busy !== 1'b1 && (ram_addr !== '0 || ram_din !== '0 || ram_we !== 1'b0 || in_ready !== 1'b0))
      idle_bad++;
    if (done === 1'b1) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_dat_q.delete();
    rd_addr_q.delete();
    we_bad = 0;
    idle_bad = 0;
    done_cnt = 0;
  endtask

  // One job. Returns mid-cycle in the done cycle so a following call starts in that same cycle.
  task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] l, input int gap_mode,
                         input bit corr, input bit poke);
    int n, sent, it, acc, ea;
    logic v;
    logic hit;
    logic [DW-1:0] exp_chk;
    logic [0:6] pat;
    n = int'(l) + 1;
    pat = 7'b1001101;
    if (data_q.size() == 0)
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
    clear_logs();
    corrupt = corr;
    start = 1'b1;
    base_addr = b;
    len_m1 = l;
    tick();
    start = 1'b0;
    acc = cyc;
    if (poke) begin
      base_addr = b ^ 11'h2A5;
      len_m1 = l ^ 11'h001;
    end
    sent = 0;
    it = 0;
    while (sent < n && it < 4 * n + 20) begin
      case (gap_mode)
        0: v = 1'b1;
        1: v = (it < 7) ? pat[it] : 1'b1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data = v ? data_q[sent] : 8'($urandom);
      start = poke && (it == 1);
      tick();
      if (v) sent++;
      it++;
    end
    in_valid = 1'b0;
    start = poke;  // lands in READ
    tick();
    start = 1'b0;
    for (int k = 0; k < n + 50 && done !== 1'b1; k++) tick();
    #5;
    // Reference: expected checksum and addresses from the byte list and base.
    exp_chk = '0;
    hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_chk ^= data_q[i];
      if (corr && ((int'(b) + i) % DEPTH) == 2) hit = 1'b1;
    end
    check("done_seen", done, 1'b1);
    check("done_count", done_cnt, 1);
    if (gap_mode == 0) check("latency", done_cyc - acc + 1, 2 * n + 2);
    check("error", error, hit);
    check("chk", chk, exp_chk ^ {7'b0, hit});
    check("busy_at_done", busy, 1'b0);
    check("wr_count", wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      ea = (int'(b) + i) % DEPTH;
      check("wr_addr", wr_addr_q[i], ea);
      check("wr_data", wr_dat_q[i], data_q[i]);
    end
    check("rd_cycles", rd_addr_q.size(), n + 1);
    for (int i = 0; i < n && i < rd_addr_q.size(); i++) begin
      ea = (int'(b) + i) % DEPTH;
      check("rd_addr", rd_addr_q[i], ea);
    end
    check("we_on_gap", we_bad, 0);
    check("idle_outputs", idle_bad, 0);
    data_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rb, rl;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len_m1 = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_chk", chk, 8'h00);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 11'h000);
    check("rst_ram_din", ram_din, 8'h00);
    rst = 1'b0;
    tick();

    // Basic job with known bytes.
    data_q = '{8'h48, 8'h0F, 8'h4C, 8'hFE};
    run_job(11'h000, 11'd3, 0, 1'b0, 1'b0);
    check("basic_chk_value", chk, 8'hF5);
    tick();
    check("done_one_cycle", done, 1'b0);
    repeat (3) tick();
    check("chk_hold", chk, 8'hF5);
    check("error_hold0", error, 1'b0);

    // Address wrap-around.
    tick();
    run_job(11'h7FE, 11'd3, 0, 1'b0, 1'b0);

    // Fixed backpressure pattern 1,0,0,1,1,0,1.
    tick();
    run_job(11'h123, 11'd3, 1, 1'b0, 1'b0);

    // Readback corruption at address 2.
    tick();
    run_job(11'h000, 11'd5, 0, 1'b1, 1'b0);
    repeat (2) tick();
    check("error_hold1", error, 1'b1);

    // Reset in the middle of WRITE after two handshakes.
    tick();
    clear_logs();
    corrupt = 1'b0;
    start = 1'b1;
    base_addr = 11'h100;
    len_m1 = 11'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      tick();
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_ram_we", ram_we, 1'b0);
    check("midrst_ram_addr", ram_addr, 11'h000);
    repeat (3) tick();
    check("midrst_no_done", done_cnt, 0);
    check("midrst_writes", wr_addr_q.size(), 2);
    check("midrst_error", error, 1'b0);
    check("midrst_chk", chk, 8'h00);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    run_job(11'h040, 11'd3, 0, 1'b0, 1'b0);

    // Start pulses while busy must be ignored.
    tick();
    run_job(11'h200, 11'd7, 0, 1'b0, 1'b1);
    // Start in the done cycle of the previous job.
    run_job(11'h3F0, 11'd2, 0, 1'b0, 1'b0);

    // Randomized jobs, including single-byte and back-to-back starts.
    for (int r = 0; r < 12; r++) begin
      rb = AW'($urandom);
      rl = (r == 0) ? 11'd0 : AW'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 0) tick();
      run_job(rb, rl, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              (rl != 0) && ($urandom_range(0, 1) == 1));
    end

    // Full-size job wrapping through address 2.
    tick();
    run_job(11'h5A0, 11'h7FF, 0, 1'b1, 1'b0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
